// File: rtl/la_rrarb4_pkg.sv
// Shared definitions for the la_rrarb4 round-robin arbiter.
// Holds the state encoding, the requester count and an index helper.
package la_rrarb4_pkg;

    localparam int N = 4;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    function automatic logic [1:0] oh2idx(input logic [N-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/la_rrpick4.sv
// Combinational rotate-priority picker: first set req bit at or after ptr.
// Produces a one-hot select and a valid flag.
module la_rrpick4
    import la_rrarb4_pkg::*;
(
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] sel,
    output logic         valid
);

    logic [1:0] idx;

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + 2'(k);
            if (!valid && req[idx]) begin
                sel[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/la_rrarb4.sv
// Four-requester round-robin arbiter with a registered one-hot grant.
// HOLD selects hold-until-release or one-cycle-per-round grants.
module la_rrarb4
    import la_rrarb4_pkg::*;
#(
    parameter string PROP = "DEFAULT",
    parameter bit    HOLD = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any,
    output logic         busy
);

    logic         state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic         busy_q, busy_d;
    logic [N-1:0] sel;
    logic         valid;
    logic         keep;

    // PROP only steers technology mapping; nothing functional hangs off it.
    if (PROP != "DEFAULT") begin : g_prop_custom
    end

    la_rrpick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .sel   (sel),
        .valid (valid)
    );

    assign keep = HOLD && (state_q == GRANT) && (|(req & gnt_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (keep) begin
            state_d = GRANT;
        end else if (valid) begin
            state_d = GRANT;
            ptr_d   = oh2idx(sel) + 2'd1;
        end else begin
            state_d = IDLE;
        end
    end

    always_comb begin
        gnt_d  = keep ? gnt_q : sel;
        busy_d = |gnt_d;
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign any  = |req;

    a_onehot0: assert property (
        @(posedge clk) disable iff (reset) $onehot0(gnt_q));
    a_busy: assert property (
        @(posedge clk) disable iff (reset) busy_q == (|gnt_q));

endmodule

// File: tb/tb_la_rrarb4.sv
// Directed and randomized bench for la_rrarb4 with HOLD=1 and HOLD=0.
// Expected values are hand-computed or come from a small behavioural model.
module tb_la_rrarb4;

    logic       clk;
    logic       reset;
    logic [3:0] req1, req0;
    logic [3:0] gnt1, gnt0;
    logic       any1, any0;
    logic       busy1, busy0;

    int total = 0;
    int bad   = 0;

    la_rrarb4 #(.PROP("DEFAULT"), .HOLD(1'b1)) u_h1 (
        .clk   (clk),
        .reset (reset),
        .req   (req1),
        .gnt   (gnt1),
        .any   (any1),
        .busy  (busy1)
    );

    la_rrarb4 #(.PROP("DEFAULT"), .HOLD(1'b0)) u_h0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .gnt   (gnt0),
        .any   (any0),
        .busy  (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req1  = '0;
        req0  = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] pick(input logic [3:0] r,
                                        input logic [1:0] p);
        logic [1:0] idx;
        logic [3:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (w == 4'b0 && r[idx]) w[idx] = 1'b1;
        end
        return w;
    endfunction

    task automatic test_reset;
        req1  = 4'b1111;
        req0  = 4'b0000;
        reset = 1'b1;
        #2;
        total++;
        if (gnt1 !== 4'b0000 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_init gnt=%b busy=%b want 0000/0", gnt1, busy1);
        end
        total++;
        if (any1 !== 1'b1 || any0 !== 1'b0) begin
            bad++;
            $display("FAIL any_in_reset any1=%b any0=%b want 1/0", any1, any0);
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (gnt1 !== 4'b0001 || busy1 !== 1'b1) begin
            bad++;
            $display("FAIL first_grant gnt=%b busy=%b want 0001/1", gnt1, busy1);
        end
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (gnt1 !== 4'b0000 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset gnt=%b busy=%b want 0000/0", gnt1, busy1);
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (gnt1 !== 4'b0001) begin
            bad++;
            $display("FAIL grant_after_reset gnt=%b want 0001", gnt1);
        end
    endtask

    task automatic test_single_hold;
        do_reset();
        req1 = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (gnt1 !== 4'b0100 || busy1 !== 1'b1) begin
                bad++;
                $display("FAIL single_hold c%0d gnt=%b busy=%b want 0100/1",
                         c, gnt1, busy1);
            end
        end
        req1 = 4'b0000;
        tick();
        total++;
        if (gnt1 !== 4'b0000 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL single_release gnt=%b busy=%b want 0000/0", gnt1, busy1);
        end
    endtask

    task automatic test_fairness;
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        req0 = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            total++;
            if (gnt0 !== exp_seq[c]) begin
                bad++;
                $display("FAIL fairness c%0d gnt=%b want %b", c, gnt0, exp_seq[c]);
            end
        end
        req0 = 4'b0000;
        tick();
        total++;
        if (gnt0 !== 4'b0000 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL fairness_idle gnt=%b busy=%b want 0000/0", gnt0, busy0);
        end
    endtask

    task automatic test_single_hold0;
        do_reset();
        req0 = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (gnt0 !== 4'b0100) begin
                bad++;
                $display("FAIL persist_hold0 c%0d gnt=%b want 0100", c, gnt0);
            end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        req1 = 4'b0001;
        tick();
        req1 = 4'b1001;
        tick();
        total++;
        if (gnt1 !== 4'b0001) begin
            bad++;
            $display("FAIL b2b_owner gnt=%b want 0001", gnt1);
        end
        req1 = 4'b1000;
        tick();
        total++;
        if (gnt1 !== 4'b1000 || busy1 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_handover gnt=%b busy=%b want 1000/1", gnt1, busy1);
        end
        req1 = 4'b0000;
        tick();
        total++;
        if (gnt1 !== 4'b0000 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle gnt=%b busy=%b want 0000/0", gnt1, busy1);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        req1 = 4'b1000;
        req0 = 4'b1000;
        tick();
        total++;
        if (gnt1 !== 4'b1000 || gnt0 !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_req3 gnt1=%b gnt0=%b want 1000", gnt1, gnt0);
        end
        req1 = 4'b0011;
        req0 = 4'b0011;
        tick();
        total++;
        if (gnt1 !== 4'b0001 || gnt0 !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_ptr gnt1=%b gnt0=%b want 0001", gnt1, gnt0);
        end
        tick();
        total++;
        if (gnt1 !== 4'b0001 || gnt0 !== 4'b0010) begin
            bad++;
            $display("FAIL wrap_next gnt1=%b gnt0=%b want 0001/0010", gnt1, gnt0);
        end
    endtask

    task automatic test_stress;
        logic [3:0] m1, m0;
        logic [1:0] p1, p0;
        logic [3:0] w;
        int         wait0 [4];
        do_reset();
        m1 = '0;
        m0 = '0;
        p1 = '0;
        p0 = '0;
        for (int i = 0; i < 4; i++) wait0[i] = 0;
        for (int c = 0; c < 5000; c++) begin
            req1 = 4'($urandom_range(0, 15));
            req0 = 4'($urandom_range(0, 15));
            if (!((m1 & req1) != 0)) begin
                w  = pick(req1, p1);
                m1 = w;
                for (int i = 0; i < 4; i++) if (w[i]) p1 = 2'(i + 1);
            end
            w  = pick(req0, p0);
            m0 = w;
            for (int i = 0; i < 4; i++) if (w[i]) p0 = 2'(i + 1);
            for (int i = 0; i < 4; i++) begin
                if (!req0[i] || m0[i]) wait0[i] = 0;
                else if (m0 != 0) wait0[i]++;
            end
            tick();
            total++;
            if (gnt1 !== m1 || busy1 !== (|m1) || any1 !== (|req1)) begin
                bad++;
                $display("FAIL stress_h1 c%0d req=%b gnt=%b busy=%b want %b",
                         c, req1, gnt1, busy1, m1);
            end
            total++;
            if (gnt0 !== m0 || busy0 !== (|m0) || any0 !== (|req0)) begin
                bad++;
                $display("FAIL stress_h0 c%0d req=%b gnt=%b busy=%b want %b",
                         c, req0, gnt0, busy0, m0);
            end
            total++;
            if (!$onehot0(gnt0) || !$onehot0(gnt1) ||
                wait0[0] > 3 || wait0[1] > 3 ||
                wait0[2] > 3 || wait0[3] > 3) begin
                bad++;
                $display("FAIL stress_inv c%0d gnt0=%b gnt1=%b wait=%0d,%0d,%0d,%0d",
                         c, gnt0, gnt1, wait0[0], wait0[1], wait0[2], wait0[3]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req1  = '0;
        req0  = '0;
        test_reset();
        test_single_hold();
        test_fairness();
        test_single_hold0();
        test_back_to_back();
        test_wrap();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
